// File: rtl/axi_sram_responder.sv
// axi_sram_responder: single-beat AXI4 slave over a 64-bit word array, one transaction at a time.
// Define AXI_SRAM_RESP_EXCL_EN to add a single exclusive-access reservation (EXOKAY support).
module axi_sram_responder #(
    parameter int unsigned NumWords = 1024,
    parameter int unsigned IdWidth = 4,
    parameter int unsigned AddrWidth = 64,
    parameter logic [AddrWidth-1:0] BaseAddr = AddrWidth'(64'h8000_0000)
) (
    input  logic                 clk_i,
    input  logic                 clr_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic [2:0]           aw_size_i,
    input  logic                 aw_lock_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic [63:0]          w_data_i,
    input  logic [7:0]           w_strb_i,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [2:0]           ar_size_i,
    input  logic                 ar_lock_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [63:0]          r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o
);
    localparam int unsigned IdxW = $clog2(NumWords);
    localparam logic [AddrWidth-1:0] EndAddr = BaseAddr + (AddrWidth'(NumWords) << 3);

    typedef enum logic [1:0] {IDLE, WAITW, WRESP, RRESP} state_e;

    function automatic logic in_range(input logic [AddrWidth-1:0] a);
        return a >= BaseAddr && a < EndAddr;
    endfunction

    function automatic logic [IdxW-1:0] word_idx(input logic [AddrWidth-1:0] a);
        return IdxW'((a - BaseAddr) >> 3);
    endfunction

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   aw_addr_q;
    logic [IdWidth-1:0]     b_id_q, r_id_q;
    logic [1:0]             b_resp_q, b_resp_d, r_resp_q, r_resp_d;
    logic [63:0]            r_data_q;
    logic [63:0]            mem_q [NumWords];
    logic                   aw_hs, ar_hs, w_hs, ar_in, w_err, wr_en, excl_ok, excl_wr;

    always_comb begin
        state_d    = state_q;
        aw_ready_o = 1'b0;
        ar_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        r_valid_o  = 1'b0;
        if (!clr_i) begin
            unique case (state_q)
                IDLE: begin
                    aw_ready_o = 1'b1;
                    ar_ready_o = !aw_valid_i;
                    state_d    = aw_valid_i ? WAITW : ar_valid_i ? RRESP : IDLE;
                end
                WAITW: begin
                    w_ready_o = 1'b1;
                    state_d   = w_valid_i ? WRESP : WAITW;
                end
                WRESP: begin
                    b_valid_o = 1'b1;
                    state_d   = b_ready_i ? IDLE : WRESP;
                end
                RRESP: begin
                    r_valid_o = 1'b1;
                    state_d   = r_ready_i ? IDLE : RRESP;
                end
            endcase
        end
    end

    assign aw_hs    = aw_valid_i & aw_ready_o;
    assign ar_hs    = ar_valid_i & ar_ready_o;
    assign w_hs     = w_valid_i & w_ready_o;
    assign ar_in    = in_range(ar_addr_i);
    assign w_err    = !in_range(aw_addr_q) || !w_last_i;
    assign wr_en    = w_hs && !w_err && excl_ok;
    assign b_resp_d = w_err ? 2'b10 : excl_wr ? 2'b01 : 2'b00;

`ifdef AXI_SRAM_RESP_EXCL_EN
    logic                 aw_lock_q, resv_valid_q, resv_hit;
    logic [AddrWidth-4:0] resv_addr_q;
    logic [IdWidth-1:0]   resv_id_q;

    assign resv_hit = resv_valid_q && resv_addr_q == aw_addr_q[AddrWidth-1:3];
    assign excl_wr  = aw_lock_q && resv_hit && resv_id_q == b_id_q;
    assign excl_ok  = !aw_lock_q || excl_wr;
    assign r_resp_d = !ar_in ? 2'b10 : ar_lock_i ? 2'b01 : 2'b00;

    // Any committed write to the reserved dword (exclusive or not) kills the reservation.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            aw_lock_q    <= 1'b0;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
            resv_id_q    <= '0;
        end else begin
            if (aw_hs) aw_lock_q <= aw_lock_i;
            if (ar_hs && ar_lock_i && ar_in) begin
                resv_valid_q <= 1'b1;
                resv_addr_q  <= ar_addr_i[AddrWidth-1:3];
                resv_id_q    <= ar_id_i;
            end else if (wr_en && resv_hit) begin
                resv_valid_q <= 1'b0;
            end
        end
    end
`else
    logic unused_lock;
    assign excl_wr     = 1'b0;
    assign excl_ok     = 1'b1;
    assign r_resp_d    = ar_in ? 2'b00 : 2'b10;
    assign unused_lock = aw_lock_i ^ ar_lock_i;
`endif

    logic unused_size;
    assign unused_size = ^{aw_size_i, ar_size_i};

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q   <= IDLE;
            aw_addr_q <= '0;
            b_id_q    <= '0;
            b_resp_q  <= '0;
            r_id_q    <= '0;
            r_data_q  <= '0;
            r_resp_q  <= '0;
        end else begin
            state_q <= state_d;
            if (aw_hs) begin
                aw_addr_q <= aw_addr_i;
                b_id_q    <= aw_id_i;
            end
            if (w_hs) b_resp_q <= b_resp_d;
            if (ar_hs) begin
                r_id_q   <= ar_id_i;
                r_data_q <= ar_in ? mem_q[word_idx(ar_addr_i)] : '0;
                r_resp_q <= r_resp_d;
            end
        end
    end

    // Backing store is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (wr_en)
            for (int k = 0; k < 8; k++)
                if (w_strb_i[k]) mem_q[word_idx(aw_addr_q)][8*k +: 8] <= w_data_i[8*k +: 8];
    end

    assign b_id_o   = b_id_q;
    assign b_resp_o = b_resp_q;
    assign r_id_o   = r_id_q;
    assign r_data_o = r_data_q;
    assign r_resp_o = r_resp_q;
    assign r_last_o = r_valid_o;
endmodule

// File: doc/axi_sram_responder.md
Name: axi_sram_responder

Overview:
- Single-beat AXI4 slave backed by an internal 64-bit-wide register array.
- Terminates the data port that the bypass/no-dcache load/store/AMO master drives, for unit tests and small SoC scratchpads.
- Serialises one transaction at a time: AW/W/B or AR/R.
- Returns OKAY, SLVERR, or EXOKAY (exclusive access, optional).

Parameters:
- NumWords, 1024, depth of backing array in 64-bit words; power of two.
- IdWidth, 4, AXI ID width.
- AddrWidth, 64, AXI address width.
- BaseAddr, 64'h8000_0000, first byte address served; NumWords*8 bytes from here.

Ports:
- clk_i  in  1  clock
- clr_i  in  1  synchronous active-high reset
- aw_valid_i  in  1  write address valid
- aw_ready_o  out  1  write address ready
- aw_id_i  in  IdWidth  write ID
- aw_addr_i  in  AddrWidth  write byte address
- aw_size_i  in  3  write size (log2 bytes)
- aw_lock_i  in  1  exclusive write
- w_valid_i  in  1  write data valid
- w_ready_o  out  1  write data ready
- w_data_i  in  64  write data, lane-aligned
- w_strb_i  in  8  byte strobes
- w_last_i  in  1  last beat; must be 1
- b_valid_o  out  1  write response valid
- b_ready_i  in  1  write response ready
- b_id_o  out  IdWidth  echoed AW ID
- b_resp_o  out  2  00 OKAY, 01 EXOKAY, 10 SLVERR
- ar_valid_i  in  1  read address valid
- ar_ready_o  out  1  read address ready
- ar_id_i  in  IdWidth  read ID
- ar_addr_i  in  AddrWidth  read byte address
- ar_size_i  in  3  read size
- ar_lock_i  in  1  exclusive read
- r_valid_o  out  1  read data valid
- r_ready_i  in  1  read data ready
- r_id_o  out  IdWidth  echoed AR ID
- r_data_o  out  64  full 64-bit word at addr[AddrWidth-1:3]
- r_resp_o  out  2  OKAY / EXOKAY / SLVERR
- r_last_o  out  1  always equals r_valid_o

Behaviour:
- Reset:
  - clk_i only; clr_i high forces state Idle, reservation invalid, all *_ready_o and *_valid_o 0, id/resp/data outputs 0.
  - Array contents are not reset.
- Address decode:
  - in_range = (addr >= BaseAddr) && (addr < BaseAddr + NumWords*8).
  - index = (addr - BaseAddr) >> 3, log2(NumWords) bits.
- States: Idle, WaitW, WriteResp, ReadResp.
- Idle:
  - aw_ready_o = 1 (not during clr_i).
  - ar_ready_o = !aw_valid_i: writes win over simultaneous reads; the read stays pending and is accepted the next time Idle is reached.
  - AW handshake: latch id, addr, lock -> WaitW.
  - AR handshake: latch id; register r_data_o = array[index] (0 if out of range); set r_resp_o -> ReadResp.
  - Read latency: AR handshake cycle N -> r_valid_o high in N+1.
- WaitW:
  - w_ready_o = 1; all other readys 0.
  - On w_valid_i, commit the write at that edge: array bytes with w_strb_i[k]=1 take w_data_i[8k+7:8k]. No write if out of range, w_last_i=0, or an exclusive write fails.
  - Set b_resp_o, then -> WriteResp.
  - W arriving before AW is not accepted (w_ready_o low).
- WriteResp: b_valid_o = 1 with b_id_o/b_resp_o held stable until b_ready_i; handshake -> Idle.
- ReadResp: r_valid_o = r_last_o = 1; r_id_o, r_data_o, r_resp_o held stable until r_ready_i; handshake -> Idle.
- Response codes:
  - SLVERR: out of range, or write with w_last_i=0.
  - OKAY: all other non-exclusive accesses.
- Minimum cycles per transaction:
  - write: 3 (AW, W, B);
  - read: 2 (AR, R).
- aw_size_i/ar_size_i are informational only; strobes govern write bytes.
- clr_i mid-transaction: the transaction is abandoned with no response and no partial write after the clr_i edge. A W already committed stays committed.

Optional Feature:
- Macro AXI_SRAM_RESP_EXCL_EN.
- Defined: one reservation register {valid, addr[AddrWidth-1:3], id}.
  - Exclusive read (ar_lock_i=1, in range): sets the reservation; r_resp_o = EXOKAY.
  - Exclusive write, reservation valid and dword address and id match: write performed, b_resp = EXOKAY, reservation cleared.
  - Exclusive write otherwise: no write, b_resp = OKAY.
  - Any non-exclusive successful write to the reserved dword clears the reservation.
  - A new exclusive read replaces the reservation.
- Undefined: aw_lock_i/ar_lock_i are ignored, EXOKAY is never returned, and no reservation logic is present.

Test Plan:
- AW addr 0x8000_0010, W data 0x1122334455667788 strb 0xFF, then AR same addr -> B OKAY; R data 0x1122334455667788 OKAY, r_valid one cycle after AR handshake.
- Pre-filled word 0xFFFF_FFFF_FFFF_FFFF, W data 0 strb 0x0F -> read returns 0xFFFF_FFFF_0000_0000.
- AR addr 0x7FFF_FFF8 and AW addr BaseAddr+NumWords*8 -> R SLVERR data 0; B SLVERR; array unchanged.
- aw_valid and ar_valid both high in Idle -> write completes first, read accepted the cycle after the B handshake; b_ready/r_ready held low 5 cycles -> outputs stable, no new handshakes.
- EXCL_EN: exclusive read 0x8000_0020 id 3, exclusive write same addr/id -> EXOKAY, written. Second exclusive write -> OKAY, not written. Normal write between read and write -> exclusive write fails.
- clr_i pulsed while in ReadResp and while in WaitW -> next cycle all valid/ready 0, state Idle, no write performed, subsequent transaction normal.
